pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 45 ++++
 rtl/pipeline_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: branch/jump opcodes, the hazard controller
// FSM state encoding and a register-match helper. Also imported by
// control_unit so both blocks decode opcodes from the same constants.
// No ports (package).

package pipeline_hazard_ctrl_pkg;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALTED = 2'b01
    } hazard_state_t;

    // True when a producer register r is a real register read by the ID
    // instruction; the hard-wired zero register never creates a dependence.
    function automatic logic reg_match(input logic [4:0] r,
                                       input logic [4:0] rzero,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt);
        return (r != rzero) && ((r == rs) || (r == rt));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: purely combinational decode of the instruction in ID and
// detection of data hazards that forwarding cannot cover.
// Ports:
//   id_valid, id_opcode, id_rs, id_rt      - instruction in ID
//   ex_rd, ex_reg_write, ex_mem_read       - producer in EX
//   mem_rd, mem_mem_read                   - producer in MEM
//   is_branch, is_jump                     - decoded control-flow class
//   hazard                                 - ID must stall this cycle

module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter logic [4:0] RZERO = 5'd0
) (
    input  logic       id_valid,
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       mem_mem_read,
    output logic       is_branch,
    output logic       is_jump,
    output logic       hazard
);

    logic ex_match;
    logic mem_match;

    // Branches resolve in ID, so they also wait for ALU results still in EX
    // and for loads still in MEM. Jumps carry an address, not source
    // registers, so their rs/rt fields are never treated as dependences.
    always_comb begin
        is_branch = id_valid && ((id_opcode == OP_BEQ) || (id_opcode == OP_BNE));
        is_jump   = id_valid && ((id_opcode == OP_J) || (id_opcode == OP_JAL));
        ex_match  = !is_jump && reg_match(ex_rd, RZERO, id_rs, id_rt);
        mem_match = !is_jump && reg_match(mem_rd, RZERO, id_rs, id_rt);
        hazard    = id_valid && ((ex_mem_read && ex_match)
                              || (is_branch && ex_reg_write && ex_match)
                              || (is_branch && mem_mem_read && mem_match));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/freeze control for a 5-stage pipeline
// with branches resolved in ID, plus saturating stall/flush counters.
// Ports:
//   clk, rst_n                               - clock, async active-low reset
//   id_* / ex_* / mem_*                      - stage information for hazards
//   branch_taken                             - ID branch comparator result
//   halt_req                                 - debug freeze request (level)
//   cnt_clr                                  - synchronous counter clear
//   pc_write, ifid_write                     - PC and IF/ID enables
//   idex_bubble, ifid_flush                  - bubble into EX, squash IF/ID
//   pipe_en                                  - global register enable
//   halt_ack                                 - pipeline is frozen
//   stall_cnt, flush_cnt                     - saturating event counters

module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int         CNT_W = 16,
    parameter logic [4:0] RZERO = 5'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_mem_read,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             pipe_en,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hazard_state_t state;
    logic          is_branch;
    logic          is_jump;
    logic          hazard;
    logic          redirect;

    hazard_detect #(
        .RZERO(RZERO)
    ) u_hazard_detect (
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_rd       (ex_rd),
        .ex_reg_write(ex_reg_write),
        .ex_mem_read (ex_mem_read),
        .mem_rd      (mem_rd),
        .mem_mem_read(mem_mem_read),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .hazard      (hazard)
    );

    assign redirect = is_jump || (is_branch && branch_taken);

    // Pipeline enables are combinational so a hazard stalls in the same
    // cycle it is seen. Reset forces free-running enables regardless of the
    // stage inputs; a stall always beats a redirect since the branch
    // operands are not yet valid.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        pipe_en     = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (rst_n) begin
            if (state == ST_HALTED) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_en    = 1'b0;
            end else if (hazard) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else if (redirect) begin
                ifid_flush = 1'b1;
            end
        end
    end

    // Freeze only on a clean cycle (no stall, no squash) so no partially
    // handled hazard or redirect is lost while frozen. halt_ack tracks the
    // registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            halt_ack <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req && !hazard && !redirect) begin
                        state    <= ST_HALTED;
                        halt_ack <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!halt_req) begin
                        state    <= ST_RUN;
                        halt_ack <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    halt_ack <= 1'b0;
                end
            endcase
        end
    end

    // Counters only see RUN-state events (idex_bubble/ifid_flush are already
    // zero when frozen), saturate at all-ones, and clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (idex_bubble && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, away from the rising edge.

module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int         CNT_W  = 16;
    localparam logic [5:0] OP_ALU = 6'h00;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [4:0]       mem_rd;
    logic             mem_mem_read;
    logic             branch_taken;
    logic             halt_req;
    logic             cnt_clr;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             pipe_en;
    logic             halt_ack;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(
        .CNT_W(CNT_W),
        .RZERO(5'd0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_rd       (ex_rd),
        .ex_reg_write(ex_reg_write),
        .ex_mem_read (ex_mem_read),
        .mem_rd      (mem_rd),
        .mem_mem_read(mem_mem_read),
        .branch_taken(branch_taken),
        .halt_req    (halt_req),
        .cnt_clr     (cnt_clr),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .idex_bubble (idex_bubble),
        .ifid_flush  (ifid_flush),
        .pipe_en     (pipe_en),
        .halt_ack    (halt_ack),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stage inputs on the falling edge, then settle.
    task automatic applyStimulus(input logic       v,
                                 input logic [5:0] op,
                                 input logic [4:0] rs,
                                 input logic [4:0] rt,
                                 input logic [4:0] e_rd,
                                 input logic       e_rw,
                                 input logic       e_mr,
                                 input logic [4:0] m_rd,
                                 input logic       m_mr,
                                 input logic       br,
                                 input logic       halt,
                                 input logic       clr);
        @(negedge clk);
        id_valid     = v;
        id_opcode    = op;
        id_rs        = rs;
        id_rt        = rt;
        ex_rd        = e_rd;
        ex_reg_write = e_rw;
        ex_mem_read  = e_mr;
        mem_rd       = m_rd;
        mem_mem_read = m_mr;
        branch_taken = br;
        halt_req     = halt;
        cnt_clr      = clr;
        #1;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkCtrl(input string tag,
                             input logic pc, input logic ifid, input logic bub,
                             input logic fl, input logic pe);
        checkOutput({tag, ".pc_write"},    32'(pc_write),    32'(pc));
        checkOutput({tag, ".ifid_write"},  32'(ifid_write),  32'(ifid));
        checkOutput({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
        checkOutput({tag, ".ifid_flush"},  32'(ifid_flush),  32'(fl));
        checkOutput({tag, ".pipe_en"},     32'(pipe_en),     32'(pe));
    endtask

    task automatic checkCounters(input string tag, input int st, input int fl);
        checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(st));
        checkOutput({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(fl));
    endtask

    initial begin
        // Reset with a load-use pattern on the inputs: enables stay free-running
        rst_n        = 1'b0;
        id_valid     = 1'b1;
        id_opcode    = OP_ALU;
        id_rs        = 5'd5;
        id_rt        = 5'd2;
        ex_rd        = 5'd5;
        ex_reg_write = 1'b1;
        ex_mem_read  = 1'b1;
        mem_rd       = 5'd0;
        mem_mem_read = 1'b0;
        branch_taken = 1'b1;
        halt_req     = 1'b0;
        cnt_clr      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkCtrl("reset", 1, 1, 0, 0, 1);
        checkOutput("reset.halt_ack", 32'(halt_ack), 32'd0);
        checkCounters("reset", 0, 0);
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Load-use on ALU instruction: exactly one stall
        applyStimulus(1, OP_ALU, 5, 2, 5, 1, 1, 0, 0, 0, 0, 0);
        checkCtrl("lduse", 0, 0, 1, 0, 1);
        applyStimulus(1, OP_ALU, 5, 2, 0, 0, 0, 5, 1, 0, 0, 0);
        checkCtrl("lduse_done", 1, 1, 0, 0, 1);
        checkCounters("lduse_done", 1, 0);

        // Load to the zero register never stalls
        applyStimulus(1, OP_ALU, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        checkCtrl("rzero", 1, 1, 0, 0, 1);
        checkCounters("rzero", 1, 0);

        // Clear, then load followed by dependent taken BEQ: 2 stalls, 1 flush
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, OP_BEQ, 7, 3, 7, 1, 1, 0, 0, 1, 0, 0);
        checkCounters("clr", 0, 0);
        checkCtrl("beq_ex", 0, 0, 1, 0, 1);
        applyStimulus(1, OP_BEQ, 7, 3, 0, 0, 0, 7, 1, 1, 0, 0);
        checkCtrl("beq_mem", 0, 0, 1, 0, 1);
        applyStimulus(1, OP_BEQ, 7, 3, 0, 0, 0, 0, 0, 1, 0, 0);
        checkCtrl("beq_taken", 1, 1, 0, 1, 1);
        checkCounters("beq_taken", 2, 0);
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkCtrl("beq_after", 1, 1, 0, 0, 1);
        checkCounters("beq_after", 2, 1);

        // BNE depending via rt on an ALU result in EX stalls
        applyStimulus(1, OP_BNE, 9, 4, 4, 1, 0, 0, 0, 1, 0, 0);
        checkCtrl("bne_alu", 0, 0, 1, 0, 1);
        // ALU instruction on an ALU result in EX is forwarded, no stall
        applyStimulus(1, OP_ALU, 4, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        checkCtrl("alu_fwd", 1, 1, 0, 0, 1);
        checkCounters("alu_fwd", 3, 1);
        // Not-taken branch without hazard: no flush
        applyStimulus(1, OP_BEQ, 8, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        checkCtrl("beq_nt", 1, 1, 0, 0, 1);
        // Jump flushes; its rs field aliasing a load destination is not a hazard
        applyStimulus(1, OP_J, 6, 0, 6, 1, 1, 0, 0, 0, 0, 0);
        checkCtrl("jump", 1, 1, 0, 1, 1);
        // Invalid ID slot: neither JAL flush nor load-use stall
        applyStimulus(0, OP_JAL, 6, 0, 6, 1, 1, 0, 0, 0, 0, 0);
        checkCtrl("invalid", 1, 1, 0, 0, 1);
        checkCounters("invalid", 3, 2);

        // Halt requested during a hazard waits for the hazard to clear
        applyStimulus(1, OP_ALU, 5, 2, 5, 1, 1, 0, 0, 0, 1, 0);
        checkCtrl("halt_hz", 0, 0, 1, 0, 1);
        checkOutput("halt_hz.halt_ack", 32'(halt_ack), 32'd0);
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkCtrl("halt_clean", 1, 1, 0, 0, 1);
        checkOutput("halt_clean.halt_ack", 32'(halt_ack), 32'd0);
        applyStimulus(1, OP_ALU, 5, 2, 5, 1, 1, 0, 0, 0, 1, 0);
        checkCtrl("halted", 0, 0, 0, 0, 0);
        checkOutput("halted.halt_ack", 32'(halt_ack), 32'd1);
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkCtrl("halted_rel", 0, 0, 0, 0, 0);
        checkOutput("halted_rel.halt_ack", 32'(halt_ack), 32'd1);
        checkCounters("halted_rel", 4, 2);
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkCtrl("resumed", 1, 1, 0, 0, 1);
        checkOutput("resumed.halt_ack", 32'(halt_ack), 32'd0);

        // Halt requested on a flush cycle is deferred by one cycle
        applyStimulus(1, OP_JAL, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkCtrl("halt_fl", 1, 1, 0, 1, 1);
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("halt_fl_defer.halt_ack", 32'(halt_ack), 32'd0);
        checkCounters("halt_fl_defer", 4, 3);
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("halt_fl_in.halt_ack", 32'(halt_ack), 32'd1);
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("halt_fl_out.halt_ack", 32'(halt_ack), 32'd0);

        // Saturation: 65535 hazards reach all-ones, one more stays there
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(1, OP_ALU, 5, 2, 5, 1, 1, 0, 0, 0, 0, 0);
        end
        applyStimulus(1, OP_ALU, 5, 2, 5, 1, 1, 0, 0, 0, 0, 0);
        checkCounters("sat_full", 32'hFFFF, 0);
        applyStimulus(1, OP_ALU, 5, 2, 5, 1, 1, 0, 0, 0, 0, 0);
        checkCounters("sat_hold", 32'hFFFF, 0);
        applyStimulus(1, OP_ALU, 5, 2, 5, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkCounters("clr_wins", 0, 0);

        // Asynchronous reset in the middle of HALTED
        applyStimulus(1, OP_ALU, 5, 2, 5, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, OP_J, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("pre_rst.halt_ack", 32'(halt_ack), 32'd1);
        checkCounters("pre_rst", 1, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst.halt_ack", 32'(halt_ack), 32'd0);
        checkCounters("async_rst", 0, 0);
        checkCtrl("async_rst", 1, 1, 0, 0, 1);
        halt_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkCtrl("post_rst", 1, 1, 0, 0, 1);
        checkOutput("post_rst.halt_ack", 32'(halt_ack), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
